// File: rtl/draw_sequencer_pkg.sv
// Shared types and constants for the frame draw sequencer: state encoding,
// object-id map and a width helper.
package draw_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_ADV  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_DRAW = ST_DRAW,
        S_ADV  = ST_ADV
    } state_t;

    // Object ids as seen by the display handler; slot i maps to id i+1.
    localparam int DEFAULT_NUM_OBJ = 6;
    localparam int OBJ_NONE        = 0;
    localparam int OBJ_PLAYER      = 1;
    localparam int OBJ_ENEMY_BASE  = 2;
    localparam int OBJ_BULLET      = DEFAULT_NUM_OBJ;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/draw_sequencer_next_set_bit.sv
// Combinational find-first-set: lowest set bit of mask at or above start.
module next_set_bit #(
    parameter int N  = 6,
    parameter int IW = 4
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] index
);

    // Scanning downward lets the lowest qualifying bit win.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (IW'(i) >= start)) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Frame-level draw sequencer: optional erase pass over last frame's objects,
// then a draw pass over the active ones, with load/draw handshakes per object.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int NUM_OBJ   = 6,
    parameter int ID_W      = 4,
    parameter int LOAD_WAIT = 3,
    parameter int ERASE_EN  = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               frame_start,
    input  logic [NUM_OBJ-1:0] obj_active,
    input  logic               done,
    output logic [ID_W-1:0]    obj_sel,
    output logic               enable_load,
    output logic               enable_draw,
    output logic               erase,
    output logic               frame_busy,
    output logic               frame_done,
    output state_t             stateDbg
);

    localparam int WCW = (LOAD_WAIT > 1) ? clog2(LOAD_WAIT) : 1;
    localparam logic [WCW-1:0] LAST_WAIT = WCW'(LOAD_WAIT - 1);

    // Handshake: frame_start is a one-cycle request accepted only in IDLE;
    // done is the handler's completion strobe, observed only in DRAW. Either
    // input arriving in any other state is dropped, never queued.

    state_t             state, nextState;
    logic [ID_W-1:0]    idx, nIdx;
    logic [WCW-1:0]     waitCnt, nWait;
    logic [NUM_OBJ-1:0] drawMask, nDrawMask;
    logic [NUM_OBJ-1:0] prevMask, nPrevMask;
    logic               erasePass, nErasePass;
    logic               emptyDone, nEmptyDone;
    logic               endFrame;

    logic               useErase;
    logic [NUM_OBJ-1:0] lowMask;
    logic [NUM_OBJ-1:0] passMask;
    logic [ID_W-1:0]    nextStart;
    logic               lowFound, nextFound;
    logic [ID_W-1:0]    lowIdx, nextIdx;

    assign useErase  = (ERASE_EN != 0) && (prevMask != '0);
    // The lowest-bit search serves both frame entry and the erase-to-draw switch.
    assign lowMask   = (state == S_IDLE) ? (useErase ? prevMask : obj_active) : drawMask;
    assign passMask  = erasePass ? prevMask : drawMask;
    assign nextStart = idx + ID_W'(1);

    next_set_bit #(.N(NUM_OBJ), .IW(ID_W)) u_lowSearch (
        .mask  (lowMask),
        .start ('0),
        .found (lowFound),
        .index (lowIdx)
    );

    next_set_bit #(.N(NUM_OBJ), .IW(ID_W)) u_nextSearch (
        .mask  (passMask),
        .start (nextStart),
        .found (nextFound),
        .index (nextIdx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            idx       <= '0;
            waitCnt   <= '0;
            drawMask  <= '0;
            prevMask  <= '0;
            erasePass <= 1'b0;
            emptyDone <= 1'b0;
        end else begin
            state     <= nextState;
            idx       <= nIdx;
            waitCnt   <= nWait;
            drawMask  <= nDrawMask;
            prevMask  <= nPrevMask;
            erasePass <= nErasePass;
            emptyDone <= nEmptyDone;
        end
    end

    always_comb begin
        nextState  = state;
        nIdx       = idx;
        nWait      = waitCnt;
        nDrawMask  = drawMask;
        nPrevMask  = prevMask;
        nErasePass = erasePass;
        nEmptyDone = 1'b0;
        endFrame   = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    nDrawMask = obj_active;
                    if (lowFound) begin
                        nErasePass = useErase;
                        nIdx       = lowIdx;
                        nWait      = '0;
                        nextState  = S_LOAD;
                    end else begin
                        // Nothing to erase or draw: report the frame done next cycle.
                        nEmptyDone = 1'b1;
                        nPrevMask  = obj_active;
                    end
                end
            end
            S_LOAD: begin
                if (waitCnt == LAST_WAIT) begin
                    nWait     = '0;
                    nextState = S_DRAW;
                end else begin
                    nWait = waitCnt + WCW'(1);
                end
            end
            S_DRAW: begin
                if (done) begin
                    nextState = S_ADV;
                end
            end
            S_ADV: begin
                if (nextFound) begin
                    nIdx      = nextIdx;
                    nextState = S_LOAD;
                end else if (erasePass && lowFound) begin
                    nErasePass = 1'b0;
                    nIdx       = lowIdx;
                    nextState  = S_LOAD;
                end else begin
                    endFrame   = 1'b1;
                    nPrevMask  = drawMask;
                    nErasePass = 1'b0;
                    nextState  = S_IDLE;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    assign obj_sel     = (state == S_IDLE) ? ID_W'(OBJ_NONE) : idx + ID_W'(OBJ_PLAYER);
    assign enable_load = (state == S_LOAD);
    assign enable_draw = (state == S_DRAW);
    assign erase       = erasePass;
    assign frame_busy  = (state != S_IDLE);
    assign frame_done  = emptyDone | endFrame;
    assign stateDbg    = state;

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: table-driven frames, randomized
// frames against a per-cycle reference trace, and reset/hold corner cases.
module tb_draw_sequencer;

  localparam int NUM_OBJ   = 6;
  localparam int ID_W      = 4;
  localparam int LOAD_WAIT = 3;
  localparam int ERASE_EN  = 1;
  localparam int W         = 5 + ID_W;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               frame_start = 1'b0;
  logic [NUM_OBJ-1:0] obj_active = '0;
  logic               done = 1'b0;
  logic [ID_W-1:0]    obj_sel;
  logic               enable_load, enable_draw, erase, frame_busy, frame_done;
  draw_pkg::state_t   state_dbg;

  logic [W-1:0] obs;
  assign obs = {frame_busy, frame_done, erase, enable_load, enable_draw, obj_sel};

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  int lat_q[$];
  logic [NUM_OBJ-1:0] model_prev = '0;

  int busy_cnt, fdone_cnt, erase_objs, draw_objs;

  draw_sequencer #(
    .NUM_OBJ(NUM_OBJ), .ID_W(ID_W), .LOAD_WAIT(LOAD_WAIT), .ERASE_EN(ERASE_EN)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_start(frame_start), .obj_active(obj_active),
    .done(done), .obj_sel(obj_sel), .enable_load(enable_load), .enable_draw(enable_draw),
    .erase(erase), .frame_busy(frame_busy), .frame_done(frame_done), .stateDbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack(input logic busy, input logic fd, input logic er,
                                        input logic ld, input logic dr, input int sel);
    return {busy, fd, er, ld, dr, ID_W'(sel)};
  endfunction

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got busy/fdone/erase/load/draw/sel=%b, wanted %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  // Reference model: list of objects visited this frame, then the cycle trace they imply.
  task automatic build_frame(input logic [NUM_OBJ-1:0] mask, input int fixed_lat);
    int sel_q[$];
    bit er_q[$];
    int lat;
    if (ERASE_EN != 0 && model_prev != '0) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (model_prev[i]) begin sel_q.push_back(i + 1); er_q.push_back(1'b1); end
      end
    end
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (mask[i]) begin sel_q.push_back(i + 1); er_q.push_back(1'b0); end
    end
    if (sel_q.size() == 0) begin
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    end else begin
      for (int k = 0; k < sel_q.size(); k++) begin
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        lat_q.push_back(lat);
        repeat (LOAD_WAIT) exp_q.push_back(pack(1'b1, 1'b0, er_q[k], 1'b1, 1'b0, sel_q[k]));
        repeat (lat + 1) exp_q.push_back(pack(1'b1, 1'b0, er_q[k], 1'b0, 1'b1, sel_q[k]));
        exp_q.push_back(pack(1'b1, (k == sel_q.size() - 1), er_q[k], 1'b0, 1'b0, sel_q[k]));
      end
    end
    model_prev = mask;
  endtask

  // driver: called just after a falling edge; returns just after a falling edge.
  task automatic run_frame(input logic [NUM_OBJ-1:0] mask, input int fixed_lat,
                           input bit hold, input bit noise);
    logic [W-1:0] e;
    int draw_cnt, cur_lat;
    logic prev_load;
    build_frame(mask, hold ? 0 : fixed_lat);
    busy_cnt = 0; fdone_cnt = 0; erase_objs = 0; draw_objs = 0;
    draw_cnt = 0; cur_lat = 0; prev_load = 1'b0;
    obj_active = mask;
    frame_start = 1'b1;
    done = hold;
    @(posedge clk);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_word("trace", obs, e);
      busy_cnt  += int'(frame_busy);
      fdone_cnt += int'(frame_done);
      if (enable_load && !prev_load) begin
        if (erase) erase_objs++; else draw_objs++;
      end
      prev_load = enable_load;
      frame_start = (noise && exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) obj_active = NUM_OBJ'($urandom);
      if (hold) begin
        done = 1'b1;
      end else if (enable_draw) begin
        if (draw_cnt == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        done = (draw_cnt == cur_lat);
        draw_cnt++;
      end else begin
        draw_cnt = 0;
        done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    lat_q.delete();
    @(negedge clk);
    check_word("idle_after_frame", obs, '0);
    frame_start = 1'b0;
    done = 1'b0;
  endtask

  task automatic idle_noise(input int n);
    for (int c = 0; c < n; c++) begin
      done = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_word("idle_done_ignored", obs, '0);
    end
    done = 1'b0;
  endtask

  typedef struct {
    logic [NUM_OBJ-1:0] mask;
    int exp_erase;
    int exp_draw;
    int exp_busy;
    int exp_fdone;
  } vec_t;

  vec_t tbl[6];
  int found;

  initial begin
    // Each object takes 3 load + 3 draw (done 2 cycles after draw rises) + 1 advance.
    tbl[0] = '{6'b111111, 0, 6, 42, 1};
    tbl[1] = '{6'b100101, 6, 3, 63, 1};
    tbl[2] = '{6'b000011, 3, 2, 35, 1};
    tbl[3] = '{6'b000000, 2, 0, 14, 1};
    tbl[4] = '{6'b000000, 0, 0, 0, 1};
    tbl[5] = '{6'b100101, 0, 3, 21, 1};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_word("reset_state", obs, '0);
    resetn = 1'b1;

    for (int r = 0; r < 6; r++) begin
      run_frame(tbl[r].mask, 2, 1'b0, 1'b0);
      check_int($sformatf("tbl%0d_erase_objs", r), erase_objs, tbl[r].exp_erase);
      check_int($sformatf("tbl%0d_draw_objs", r), draw_objs, tbl[r].exp_draw);
      check_int($sformatf("tbl%0d_busy_cycles", r), busy_cnt, tbl[r].exp_busy);
      check_int($sformatf("tbl%0d_frame_done", r), fdone_cnt, tbl[r].exp_fdone);
    end

    idle_noise(5);

    // done held high for the whole frame: each DRAW lasts exactly one cycle
    run_frame(6'b011010, 0, 1'b1, 1'b0);
    check_int("hold_frame_done", fdone_cnt, 1);

    for (int f = 0; f < 25; f++) begin
      run_frame(NUM_OBJ'($urandom), -1, ($urandom_range(0, 4) == 0), 1'b1);
      check_int($sformatf("rand%0d_frame_done", f), fdone_cnt, 1);
      if (($urandom_range(0, 2)) == 0) idle_noise(2);
    end

    // Abort mid-DRAW of object 3, then the next frame must have no erase pass.
    found = 0;
    obj_active = 6'b111111;
    frame_start = 1'b1;
    for (int c = 0; c < 400 && found == 0; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (enable_draw && obj_sel == 4'd3) begin
        found = 1;
        done = 1'b0;
      end else begin
        done = enable_draw;
      end
    end
    check_int("reach_draw_obj3", found, 1);
    resetn = 1'b0;
    @(negedge clk);
    check_word("reset_mid_draw", obs, '0);
    resetn = 1'b1;
    model_prev = '0;
    run_frame(6'b001100, 1, 1'b0, 1'b0);
    check_int("post_reset_erase_objs", erase_objs, 0);
    check_int("post_reset_draw_objs", draw_objs, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
Parametrised frame-level draw sequencer for the VGA display path. It steps through NUM_OBJ sprite slots and, per frame, runs an optional erase pass over last frame's drawn objects and then a draw pass over the currently active ones. For each object it asserts load, then draw, to the display handler. Inactive slots are skipped with no dead cycles, and the sequencer returns to idle after each frame.

Parameters:
NUM_OBJ, 6, number of object slots (2..15); slot i is reported as obj_sel = i+1
ID_W, 4, width of obj_sel; must satisfy 2^ID_W > NUM_OBJ
LOAD_WAIT, 3, cycles enable_load is held before drawing each object (>=1)
ERASE_EN, 1, 1 = erase pass precedes draw pass; 0 = draw pass only

Ports:
clk  in  1  system clock
resetn  in  1  reset, synchronous, active-low
frame_start  in  1  single-cycle request to run one frame; honoured only in IDLE
obj_active  in  NUM_OBJ  per-slot active mask, sampled on an accepted frame_start
done  in  1  display handler finished the current object; honoured only in DRAW
obj_sel  out  ID_W  current object id, 1..NUM_OBJ; 0 = none
enable_load  out  1  display handler loads start coordinates for obj_sel
enable_draw  out  1  VGA plot enable
erase  out  1  1 = current pass is erase (colour forced to background)
frame_busy  out  1  high outside IDLE
frame_done  out  1  single-cycle pulse on the last cycle of a frame

Behaviour:
- States: IDLE, LOAD, DRAW, ADV. All outputs are registered, or decoded from registered state only.
- Reset: state=IDLE, obj_sel=0, enable_load=0, enable_draw=0, erase=0, frame_busy=0, frame_done=0, idx=0, wait counter=0, draw_mask=0, prev_mask=0. Reset mid-frame aborts immediately. No frame_done is issued, and prev_mask is cleared.
- IDLE + frame_start:
  - Latch draw_mask <= obj_active.
  - If ERASE_EN and prev_mask != 0: erase pass, pass mask = prev_mask.
  - Else: draw pass, pass mask = obj_active.
  - idx <= lowest set bit of the pass mask, then go to LOAD.
  - If both masks are empty: stay in IDLE and pulse frame_done on the next cycle.
- LOAD:
  - enable_load=1, enable_draw=0, obj_sel=idx+1.
  - Counter runs 0..LOAD_WAIT-1; after exactly LOAD_WAIT cycles in LOAD, go to DRAW.
- DRAW:
  - enable_draw=1, enable_load=0, obj_sel held.
  - Stay until done=1. On the done cycle enable_draw is still 1; the next cycle is ADV.
- ADV (exactly 1 cycle, both enables 0):
  - idx <= next set bit of the pass mask strictly above idx. If found, go to LOAD.
  - If none remain and the pass is erase: switch to draw pass, idx <= lowest set bit of draw_mask, go to LOAD. If draw_mask is empty, end the frame.
  - If none remain and the pass is draw: end the frame.
  - End of frame: prev_mask <= draw_mask, frame_done=1 for this cycle, then IDLE.
- Per-object latency: LOAD_WAIT + (cycles until done) + 1 (ADV).
- Per-pass state: erase=1 for the whole erase pass and 0 otherwise. obj_sel=0 in IDLE.
- Ignored inputs:
  - done outside DRAW.
  - frame_start outside IDLE (not queued).
  - obj_active changes mid-frame; the frame uses its snapshot.
- done held high across objects: each DRAW still lasts at least 1 cycle, and LOAD always lasts its full LOAD_WAIT.
- Slot wrap: indices never wrap within a pass; the highest slot is NUM_OBJ-1.

Decomposition:
- Package draw_pkg:
  - State encoding localparams.
  - Object-id constants: OBJ_NONE=0, OBJ_PLAYER=1, OBJ_ENEMY_BASE=2, OBJ_BULLET=NUM_OBJ.
  - A clog2 helper for the wait-counter width.
- Sub-module next_set_bit: combinational find-first-set at or above a start index within a NUM_OBJ-bit mask. Outputs are found and index.
- Instantiate next_set_bit twice: once for the lowest-bit search (start 0) and once for the next-bit search (start idx+1).

Test Plan:
- Reset, then the first frame: ERASE_EN=1, obj_active=6'b111111, frame_start pulse, done returned 2 cycles after each enable_draw rises.
  - No erase pass (prev_mask=0).
  - obj_sel sequence 1..6, each with 3 load cycles.
  - frame_done exactly once.
  - frame_busy high for 6*(3+3+1) cycles.
- Sparse mask: obj_active=6'b100101 -> obj_sel visits only 1, 3, 6; no cycles spent on the skipped slots.
- Erase then draw: second frame with obj_active=6'b000011 after a frame of 6'b100101.
  - Erase pass covers 1, 3, 6 with erase=1.
  - Draw pass covers 1, 2 with erase=0.
  - prev_mask becomes 6'b000011.
- Empty frame: obj_active=0 and prev_mask=0 -> frame_done one cycle after frame_start; enables never assert.
- Spurious inputs:
  - done pulses during LOAD and IDLE are ignored.
  - frame_start mid-frame is ignored: only one frame_done, and no second frame starts.
- Reset mid-DRAW of obj_sel=3:
  - The next cycle shows reset values.
  - A subsequent frame has no erase pass.
